load_ext_unit: RTL and testbench
================================

# load_ext_unit

Pipelined load-data extractor and extender for the MIPS datapath. It sits between the data-memory read port and the register-file write-back mux. It selects the addressed byte, halfword or word from a memory read word and sign- or zero-extends it to the full datapath width, covering LB/LBU/LH/LHU/LW. It is a single registered stage with a valid/ready handshake and a two-entry skid buffer, so memory-side stalls never combinationally reach the write-back side.

## Interface
- DATA_W, 32: datapath and memory word width. Power of two, at least 32.
- OFF_W, $clog2(DATA_W/8): byte-offset width. Derived; do not override.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request. Driven from a register.
- in_data  in  DATA_W  raw memory read word.
- in_off  in  OFF_W  byte offset (address low bits).
- in_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- in_signed  in  1  1 = sign-extend, 0 = zero-extend.
- in_tag  in  5  destination register number, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  extended result.
- out_tag  out  5  tag of the result.
- out_err  out  1  request was misaligned or used the reserved size.

## Operation
- Byte lanes are little-endian: byte k = in_data[8k+7:8k]; halfword j = in_data[16j+15:16j].
- Byte access: take byte in_off. Half access: take halfword in_off[OFF_W-1:1]. Word access: take the 32-bit word at in_off[OFF_W-1:2]; when DATA_W=32 this is the whole input.
- Extension: the MSB of the selected field (if in_signed=1) or 0 (if in_signed=0) fills bits DATA_W-1 up to the field width. For word access with DATA_W=32, in_signed has no effect.
- Error cases: reserved size always sets out_err=1 and forces out_data=0. Misalignment handling is defined under Configuration.
- Handshake: a transfer occurs on a cycle where valid && ready. Once out_valid is asserted, out_data, out_tag and out_err are held stable until out_ready.
- Storage is a main output register plus one skid register, giving the states EMPTY, ONE and FULL.
  - EMPTY: in_ready=1. An accepted request moves to ONE.
  - ONE: in_ready=1. Accept without drain moves the request to skid, going to FULL. Accept with drain keeps ONE. Drain without accept goes to EMPTY.
  - FULL: in_ready=0. A drain moves skid to main, going to ONE.
- Order is strictly FIFO. The stage never drops or duplicates a request.

## Timing
- Latency: 1 cycle. A request accepted on edge N appears on out_* after edge N.
- Throughput: 1 request per cycle while out_ready=1.
- in_ready depends only on registered state and has no combinational path from out_ready.
- Simultaneous accept and drain in ONE: both happen in the same cycle, and the state stays ONE.
- Reset: asserting rst_n low at any time, including mid-transfer, immediately forces out_valid=0, out_data=0, out_tag=0, out_err=0, skid cleared, state EMPTY. in_ready=1 while rst_n is low and on the first cycle after release.
- in_* are ignored when in_valid=0. out_ready is ignored when out_valid=0.

## Configuration
- LOAD_EXT_ALIGN_CHECK_EN defined:
  - Half access with in_off[0]=1 is misaligned.
  - Word access with in_off[1:0]≠0 is misaligned.
  - A misaligned request sets out_err=1 and forces out_data=0.
- LOAD_EXT_ALIGN_CHECK_EN undefined:
  - No alignment check is made. Low offset bits below the access size are ignored (truncated).
  - out_err is set only for the reserved size.

## Test plan
- Byte signed/unsigned: in_data=0x80FF7F01, off=3, size=00, signed=1 -> out_data=0xFFFFFF80. Same request with signed=0 -> out_data=0x00000080. Both appear 1 cycle after accept.
- Half: in_data=0x8001ABCD, off=2, size=01, signed=1 -> 0xFFFF8001. With off=0, signed=0 -> 0x0000ABCD.
- Misalign: off=1, size=01.
  - With macro defined -> out_err=1, out_data=0.
  - Without macro -> out_err=0, out_data = halfword 0.
- Reserved size: size=11 -> out_err=1 and out_data=0 in both builds.
- Backpressure: send tags 1,2,3 back-to-back with out_ready=0 -> in_ready drops after tag 2 is accepted. Raising out_ready then yields tags 1,2,3 in order with no loss.
- Reset mid-operation: hold state FULL, pulse rst_n low for 1 cycle -> out_valid=0 and in_ready=1 immediately. No stale tag appears after release.

Source files
------------

// File: rtl/load_ext_unit.sv
// Load-data extractor/extender (LB/LBU/LH/LHU/LW) with a one-stage registered output and a skid buffer.
// Optional alignment checking is enabled by defining LOAD_EXT_ALIGN_CHECK_EN.
module load_ext_unit #(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [4:0]        in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_tag,
  output logic              out_err
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready;

  logic [DATA_W-1:0] r_main_data;
  logic [4:0]        r_main_tag;
  logic              r_main_err;
  logic [DATA_W-1:0] r_skid_data;
  logic [4:0]        r_skid_tag;
  logic              r_skid_err;

  logic              w_accept;
  logic              w_drain;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;

  logic [OFF_W-1:0]  w_lane_off;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_ext_data;
  logic              w_ext_err;
  logic              w_misalign;

  // Keep the low `width` bits of field; fill the rest with `fill`.
  function automatic logic [DATA_W-1:0] extend_field(
    input logic [DATA_W-1:0] field,
    input int                width,
    input logic              fill
  );
    logic [DATA_W-1:0] mask;
    mask = ~({DATA_W{1'b1}} << width);
    return fill ? (field | ~mask) : (field & mask);
  endfunction

  // ---- Stage 0: lane select and extension ----
`ifdef LOAD_EXT_ALIGN_CHECK_EN
  assign w_misalign = ((in_size == 2'b01) && in_off[0]) ||
                      ((in_size == 2'b10) && (in_off[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Offset bits below the access size are dropped so the field lands at bit 0.
  always_comb begin
    w_lane_off = '0;
    case (in_size)
      2'b00:   w_lane_off = in_off;
      2'b01:   w_lane_off = in_off & ~OFF_W'(1);
      2'b10:   w_lane_off = in_off & ~OFF_W'(3);
      default: w_lane_off = '0;
    endcase
  end

  assign w_shifted = in_data >> {w_lane_off, 3'b000};

  always_comb begin
    w_ext_data = '0;
    w_ext_err  = 1'b0;
    case (in_size)
      2'b00:   w_ext_data = extend_field(w_shifted, 8,  in_signed & w_shifted[7]);
      2'b01:   w_ext_data = extend_field(w_shifted, 16, in_signed & w_shifted[15]);
      2'b10:   w_ext_data = extend_field(w_shifted, 32, in_signed & w_shifted[31]);
      default: w_ext_err  = 1'b1;
    endcase
    if (w_misalign) begin
      w_ext_data = '0;
      w_ext_err  = 1'b1;
    end
  end

  // ---- Stage 1: output register + skid control ----
  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = (r_state != S_EMPTY) & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_load_main_in = 1'b1;
          w_state_nxt    = S_ONE;
        end
      end
      S_ONE: begin
        if (w_accept && w_drain) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_load_skid = 1'b1;
          w_state_nxt = S_FULL;
        end else if (w_drain) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_drain) begin
          w_load_main_skid = 1'b1;
          w_state_nxt      = S_ONE;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // in_ready is registered from the next state, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  // Data registers are reset as well so outputs read all-zero during and after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data <= '0;
      r_main_tag  <= '0;
      r_main_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_tag  <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      if (w_load_main_in) begin
        r_main_data <= w_ext_data;
        r_main_tag  <= in_tag;
        r_main_err  <= w_ext_err;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_tag  <= r_skid_tag;
        r_main_err  <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_data <= w_ext_data;
        r_skid_tag  <= in_tag;
        r_skid_err  <= w_ext_err;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != S_EMPTY);
  assign out_data  = r_main_data;
  assign out_tag   = r_main_tag;
  assign out_err   = r_main_err;

endmodule

// File: tb/tb_load_ext_unit.sv
// Self-checking bench for load_ext_unit: vector table plus backpressure and reset sequences.
module tb_load_ext_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_off;
  logic [1:0]  in_size;
  logic        in_signed;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        sgn;
    logic [4:0]  tag;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  load_ext_unit #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_off    (in_off),
    .in_size   (in_size),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] d, input logic [1:0] off, input logic [1:0] size,
                         input logic sgn, input logic [4:0] tag, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.data = d; v.off = off; v.size = size; v.sgn = sgn; v.tag = tag;
    v.exp_data = ed; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] off, input logic [1:0] size,
                       input logic sgn, input logic [4:0] tag);
    in_valid = 1'b1; in_data = d; in_off = off; in_size = size; in_signed = sgn; in_tag = tag;
  endtask

  initial begin
    logic [4:0] got[$];
    int idx;
    logic acc;

    add_vec(32'h80FF7F01, 2'd3, 2'b00, 1'b1, 5'd1,  32'hFFFFFF80, 1'b0);
    add_vec(32'h80FF7F01, 2'd3, 2'b00, 1'b0, 5'd2,  32'h00000080, 1'b0);
    add_vec(32'h80FF7F01, 2'd0, 2'b00, 1'b1, 5'd3,  32'h00000001, 1'b0);
    add_vec(32'h80FF7F01, 2'd1, 2'b00, 1'b1, 5'd4,  32'h0000007F, 1'b0);
    add_vec(32'h80FF7F01, 2'd2, 2'b00, 1'b1, 5'd5,  32'hFFFFFFFF, 1'b0);
    add_vec(32'h80FF7F01, 2'd2, 2'b00, 1'b0, 5'd6,  32'h000000FF, 1'b0);
    add_vec(32'h8001ABCD, 2'd2, 2'b01, 1'b1, 5'd7,  32'hFFFF8001, 1'b0);
    add_vec(32'h8001ABCD, 2'd0, 2'b01, 1'b0, 5'd8,  32'h0000ABCD, 1'b0);
    add_vec(32'h8001ABCD, 2'd0, 2'b01, 1'b1, 5'd9,  32'hFFFFABCD, 1'b0);
    add_vec(32'h8001ABCD, 2'd0, 2'b10, 1'b1, 5'd10, 32'h8001ABCD, 1'b0);
    add_vec(32'h8001ABCD, 2'd0, 2'b11, 1'b1, 5'd11, 32'h00000000, 1'b1);
    add_vec(32'h8001ABCD, 2'd2, 2'b11, 1'b0, 5'd12, 32'h00000000, 1'b1);
`ifdef LOAD_EXT_ALIGN_CHECK_EN
    add_vec(32'h8001ABCD, 2'd1, 2'b01, 1'b0, 5'd13, 32'h00000000, 1'b1);
    add_vec(32'h8001ABCD, 2'd2, 2'b10, 1'b1, 5'd14, 32'h00000000, 1'b1);
`else
    add_vec(32'h8001ABCD, 2'd1, 2'b01, 1'b0, 5'd13, 32'h0000ABCD, 1'b0);
    add_vec(32'h8001ABCD, 2'd2, 2'b10, 1'b1, 5'd14, 32'h8001ABCD, 1'b0);
`endif

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_off = '0; in_size = '0;
    in_signed = 1'b0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_tag",   out_tag,   0);
    chk("rst_out_err",   out_err,   0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1);

    // Table vectors, streamed back-to-back with the consumer always ready.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].data, vecs[i].off, vecs[i].size, vecs[i].sgn, vecs[i].tag);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_data",  i), out_data,  vecs[i].exp_data);
      chk($sformatf("vec%0d_tag",   i), out_tag,   vecs[i].tag);
      chk($sformatf("vec%0d_err",   i), out_err,   vecs[i].exp_err);
    end
    @(posedge clk);
    #1 chk("drain_empty", out_valid, 0);

    // Backpressure: tags 1,2,3 with out_ready low, then released.
    idx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (idx < 3) drive(32'(idx + 1), 2'd0, 2'b00, 1'b0, 5'(idx + 1));
      else in_valid = 1'b0;
      out_ready = (cyc >= 4);
      #1;
      if (cyc == 2) chk("bp_in_ready_low", in_ready, 0);
      if (cyc == 4) chk("bp_full_valid", out_valid, 1);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got.push_back(out_tag);
        chk($sformatf("bp_data_t%0d", out_tag), out_data, 32'(out_tag));
      end
      @(posedge clk);
      if (acc) idx++;
    end
    chk("bp_count", got.size(), 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_order%0d", k), (k < got.size()) ? got[k] : 5'd0, 5'(k + 1));
    #1 chk("bp_final_empty", out_valid, 0);

    // Reset while FULL.
    out_ready = 1'b0;
    @(negedge clk); drive(32'h11, 2'd0, 2'b00, 1'b0, 5'd7);
    @(negedge clk); drive(32'h22, 2'd0, 2'b00, 1'b0, 5'd8);
    @(negedge clk); in_valid = 1'b0;
    #1 chk("full_in_ready", in_ready, 0);
    chk("full_out_tag", out_tag, 7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready",  in_ready,  1);
    chk("arst_out_tag",   out_tag,   0);
    chk("arst_out_data",  out_data,  0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("arel_in_ready", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1 chk($sformatf("arel_no_stale%0d", c), out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
